// File: rtl/dcache_ram_pkg.sv
// Shared types and width helpers for the dcache data array: way-select width,
// byte-lane count and the post-reset clear sequencer states.
package dcache_ram_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CLEAR,
    SEQ_DONE
  } seq_state_t;

  function automatic int way_width(input int num_ways);
    return (num_ways > 1) ? $clog2(num_ways) : 1;
  endfunction

  function automatic int be_width(input int data_width, input int byte_size);
    return data_width / byte_size;
  endfunction

endpackage

// File: rtl/sdpram_way.sv
// One cache way: byte-enabled write port, registered read port, one cycle read latency.
// A same-address write in the read cycle is merged into the read result (write-first); no backpressure.
module sdpram_way
  import dcache_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  localparam int BE_W      = be_width(DATA_WIDTH, BYTE_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_W-1:0]       wr_byte_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_merged;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_byte_en[b]) begin
          mem[wr_addr][b*BYTE_SIZE +: BYTE_SIZE] <= wr_data[b*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  // Lanes being written this cycle at the read address bypass the array.
  always_comb begin
    rd_merged = mem[rd_addr];
    for (int b = 0; b < BE_W; b++) begin
      if (we && (wr_addr == rd_addr) && wr_byte_en[b]) begin
        rd_merged[b*BYTE_SIZE +: BYTE_SIZE] = wr_data[b*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= rd_merged;
    end
  end

endmodule

// File: rtl/dcache_data_ram.sv
// Multi-way dcache data array; read latency 1 cycle (2 with OUTPUT_REG), writes/reads dropped while init_busy.
// DCACHE_RAM_INIT_EN enables the post-reset clear sequencer that zeroes every way.
module dcache_data_ram
  import dcache_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_SIZE  = 8,
  parameter int NUM_WAYS   = 4,
  parameter int OUTPUT_REG = 0,
  localparam int WAY_W     = way_width(NUM_WAYS),
  localparam int BE_WIDTH  = be_width(DATA_WIDTH, BYTE_SIZE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [WAY_W-1:0]               wr_way,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [BE_WIDTH-1:0]            wr_byte_en,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic [NUM_WAYS*DATA_WIDTH-1:0] rd_data,
  output logic                           rd_valid,
  output logic                           init_busy
);

  logic                           clearing;
  logic [ADDR_WIDTH-1:0]          clr_addr;
  logic                           wr_acc;
  logic                           rd_acc;
  logic [NUM_WAYS*DATA_WIDTH-1:0] way_q;

`ifdef DCACHE_RAM_INIT_EN
  seq_state_t seq_state;

  // Reset lands directly in CLEAR so the array is swept in exactly 2**ADDR_WIDTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_state <= SEQ_CLEAR;
      clr_addr  <= '0;
      init_busy <= 1'b1;
    end else begin
      case (seq_state)
        SEQ_IDLE: begin
          seq_state <= SEQ_CLEAR;
          clr_addr  <= '0;
          init_busy <= 1'b1;
        end
        SEQ_CLEAR: begin
          if (clr_addr == '1) begin
            seq_state <= SEQ_DONE;
            init_busy <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        SEQ_DONE: init_busy <= 1'b0;
        default:  seq_state <= SEQ_IDLE;
      endcase
    end
  end

  assign clearing = (seq_state == SEQ_CLEAR);
`else
  assign init_busy = 1'b0;
  assign clearing  = 1'b0;
  assign clr_addr  = '0;
`endif

  assign wr_acc = wr_en & ~init_busy;
  assign rd_acc = rd_en & ~init_busy;

  // An out-of-range wr_way matches no way, so the write is dropped.
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic                  way_we;
    logic [ADDR_WIDTH-1:0] way_addr;
    logic [BE_WIDTH-1:0]   way_be;
    logic [DATA_WIDTH-1:0] way_data;

    assign way_we   = clearing | (wr_acc & (wr_way == WAY_W'(w)));
    assign way_addr = clearing ? clr_addr : wr_addr;
    assign way_be   = clearing ? '1 : wr_byte_en;
    assign way_data = clearing ? '0 : wr_data;

    sdpram_way #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_SIZE  (BYTE_SIZE)
    ) u_way (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (way_we),
      .wr_addr    (way_addr),
      .wr_byte_en (way_be),
      .wr_data    (way_data),
      .re         (rd_acc),
      .rd_addr    (rd_addr),
      .rd_data    (way_q[w*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic vld_s1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_s1   <= 1'b0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else begin
        vld_s1   <= rd_acc;
        rd_valid <= vld_s1;
        if (vld_s1) begin
          rd_data <= way_q;
        end
      end
    end
  end else begin : g_noreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
      end
    end

    assign rd_data = way_q;
  end

endmodule

// File: tb/tb_dcache_data_ram.sv
// Bench for dcache_data_ram: a 4-way direct-output instance and a 3-way registered-output instance
// share one stimulus stream and are checked against a word-level array model.
module tb_dcache_data_ram;

`ifdef DCACHE_RAM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam int DEPTH        = 512;
  localparam int CLEAR_CYCLES = INIT_EN ? DEPTH : 0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         wr_en = 1'b0;
  logic [1:0]   wr_way = '0;
  logic [8:0]   wr_addr = '0;
  logic [3:0]   wr_byte_en = '0;
  logic [31:0]  wr_data = '0;
  logic         rd_en = 1'b0;
  logic [8:0]   rd_addr = '0;

  logic [127:0] rd_data4;
  logic         rd_valid4;
  logic         busy4;
  logic [95:0]  rd_data3;
  logic         rd_valid3;
  logic         busy3;

  always #5 clk = ~clk;

  dcache_data_ram #(
    .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_SIZE(8), .NUM_WAYS(4), .OUTPUT_REG(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr),
    .wr_byte_en(wr_byte_en), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data4), .rd_valid(rd_valid4), .init_busy(busy4)
  );

  dcache_data_ram #(
    .ADDR_WIDTH(9), .DATA_WIDTH(32), .BYTE_SIZE(8), .NUM_WAYS(3), .OUTPUT_REG(1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr),
    .wr_byte_en(wr_byte_en), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data3), .rd_valid(rd_valid3), .init_busy(busy3)
  );

  // Reference model: plain word arrays; a same-cycle read sees the array after that cycle's write.
  logic [31:0]  m4 [4][DEPTH];
  logic [31:0]  m3 [3][DEPTH];
  logic [127:0] exp4 = '0;
  logic         exp4_vld = 1'b0;
  logic [95:0]  exp3 = '0;
  logic         exp3_vld = 1'b0;
  logic [95:0]  pend3 = '0;
  logic         pend3_vld = 1'b0;
  int           busy_left = 0;
  logic         exp_busy = 1'b0;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] be);
    merge_bytes = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) merge_bytes[b*8 +: 8] = new_v[b*8 +: 8];
  endfunction

  task automatic zero_model();
    for (int a = 0; a < DEPTH; a++) begin
      for (int w = 0; w < 4; w++) m4[w][a] = '0;
      for (int w = 0; w < 3; w++) m3[w][a] = '0;
    end
  endtask

  task automatic tick();
    logic wa, ra;
    int   ww, ra_i;
    wa   = wr_en && !exp_busy;
    ra   = rd_en && !exp_busy;
    ww   = int'(wr_way);
    ra_i = int'(rd_addr);
    @(posedge clk);
    if (wa && ww < 4) m4[ww][wr_addr] = merge_bytes(m4[ww][wr_addr], wr_data, wr_byte_en);
    if (wa && ww < 3) m3[ww][wr_addr] = merge_bytes(m3[ww][wr_addr], wr_data, wr_byte_en);
    exp4_vld = ra;
    if (ra) for (int w = 0; w < 4; w++) exp4[w*32 +: 32] = m4[w][ra_i];
    exp3_vld = pend3_vld;
    if (pend3_vld) exp3 = pend3;
    pend3_vld = ra;
    if (ra) for (int w = 0; w < 3; w++) pend3[w*32 +: 32] = m3[w][ra_i];
    if (busy_left > 0) busy_left--;
    exp_busy = (busy_left > 0);
    #1;
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    exp4      = '0;
    exp4_vld  = 1'b0;
    exp3      = '0;
    exp3_vld  = 1'b0;
    pend3     = '0;
    pend3_vld = 1'b0;
    busy_left = 0;
    exp_busy  = INIT_EN;
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    busy_left = CLEAR_CYCLES;
    exp_busy  = (busy_left > 0);
    if (INIT_EN) zero_model();
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    zero_model();
    #2;
    assert_reset();
    checks++; if (rd_valid4 !== 1'b0) begin errors++; $display("FAIL reset_vld4: got %b want 0", rd_valid4); end
    checks++; if (rd_data4 !== 128'h0) begin errors++; $display("FAIL reset_dat4: got %h want 0", rd_data4); end
    checks++; if (rd_valid3 !== 1'b0) begin errors++; $display("FAIL reset_vld3: got %b want 0", rd_valid3); end
    checks++; if (rd_data3 !== 96'h0) begin errors++; $display("FAIL reset_dat3: got %h want 0", rd_data3); end
    checks++; if (busy4 !== exp_busy) begin errors++; $display("FAIL reset_busy: got %b want %b", busy4, exp_busy); end
    release_reset();
  endtask

  task automatic test_clear();
    int busy_cnt;
    rd_en = 1'b1;
    rd_addr = 9'd5;
    busy_cnt = busy4 ? 1 : 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      checks++;
      if (busy4 !== exp_busy || busy3 !== exp_busy) begin
        errors++; $display("FAIL clear_busy cyc %0d: got %b/%b want %b", i, busy4, busy3, exp_busy);
      end
      checks++;
      if (rd_valid4 !== exp4_vld) begin
        errors++; $display("FAIL clear_vld cyc %0d: got %b want %b", i, rd_valid4, exp4_vld);
      end
      if (busy4 === 1'b1 && i < DEPTH - 1) busy_cnt++;
    end
    checks++;
    if (busy_cnt !== CLEAR_CYCLES) begin
      errors++; $display("FAIL clear_len: got %0d cycles want %0d", busy_cnt, CLEAR_CYCLES);
    end
    rd_en = 1'b0;
    if (!INIT_EN) begin
      wr_en = 1'b1;
      wr_byte_en = 4'hF;
      wr_data = '0;
      for (int w = 0; w < 4; w++) begin
        for (int a = 0; a < DEPTH; a++) begin
          wr_way = w[1:0];
          wr_addr = a[8:0];
          tick();
        end
      end
      wr_en = 1'b0;
    end
    rd_en = 1'b1;
    rd_addr = 9'h1FF;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_valid4 !== 1'b1) begin errors++; $display("FAIL clear_rd_vld4: got %b want 1", rd_valid4); end
    checks++; if (rd_data4 !== 128'h0) begin errors++; $display("FAIL clear_rd_dat4: got %h want 0", rd_data4); end
    tick();
    checks++; if (rd_valid3 !== 1'b1) begin errors++; $display("FAIL clear_rd_vld3: got %b want 1", rd_valid3); end
    checks++; if (rd_data3 !== 96'h0) begin errors++; $display("FAIL clear_rd_dat3: got %h want 0", rd_data3); end
  endtask

  task automatic test_byte_enable();
    wr_en = 1'b1; wr_way = 2'd2; wr_addr = 9'h010; wr_data = 32'hAABBCCDD; wr_byte_en = 4'b1111;
    tick();
    wr_data = 32'h11223344; wr_byte_en = 4'b0101;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 9'h010;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data4 !== {32'h0, 32'hAA22CC44, 64'h0} || rd_valid4 !== 1'b1) begin
      errors++; $display("FAIL byte_en4: got %h/%b want %h/1", rd_data4, rd_valid4, {32'h0, 32'hAA22CC44, 64'h0});
    end
    tick();
    checks++;
    if (rd_data3 !== {32'hAA22CC44, 64'h0} || rd_valid3 !== 1'b1) begin
      errors++; $display("FAIL byte_en3: got %h/%b want %h/1", rd_data3, rd_valid3, {32'hAA22CC44, 64'h0});
    end
  endtask

  task automatic test_collision();
    wr_en = 1'b1; wr_byte_en = 4'hF; wr_addr = 9'h020;
    wr_way = 2'd1; wr_data = 32'h12345678;
    tick();
    wr_way = 2'd0; wr_data = 32'hCAFEF00D;
    tick();
    wr_way = 2'd1; wr_data = 32'hDEADBEEF; wr_byte_en = 4'b0011;
    rd_en = 1'b1; rd_addr = 9'h020;
    tick();
    idle_inputs();
    checks++;
    if (rd_data4 !== {64'h0, 32'h1234BEEF, 32'hCAFEF00D} || rd_valid4 !== 1'b1) begin
      errors++; $display("FAIL collision4: got %h/%b want %h/1", rd_data4, rd_valid4, {64'h0, 32'h1234BEEF, 32'hCAFEF00D});
    end
    tick();
    checks++;
    if (rd_data3 !== {32'h0, 32'h1234BEEF, 32'hCAFEF00D} || rd_valid3 !== 1'b1) begin
      errors++; $display("FAIL collision3: got %h/%b want %h/1", rd_data3, rd_valid3, {32'h0, 32'h1234BEEF, 32'hCAFEF00D});
    end
    checks++;
    if (rd_data4 !== {64'h0, 32'h1234BEEF, 32'hCAFEF00D} || rd_valid4 !== 1'b0) begin
      errors++; $display("FAIL hold4: got %h/%b want held data/0", rd_data4, rd_valid4);
    end
  endtask

  task automatic test_pipeline();
    logic [95:0] want;
    logic        want_vld;
    wr_en = 1'b1; wr_byte_en = 4'hF;
    for (int a = 1; a <= 3; a++) begin
      for (int w = 0; w < 3; w++) begin
        wr_way = w[1:0]; wr_addr = a[8:0]; wr_data = $urandom;
        tick();
      end
    end
    wr_en = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      rd_en = (t <= 3);
      rd_addr = t[8:0];
      tick();
      want_vld = (t >= 2 && t <= 4);
      checks++;
      if (rd_valid3 !== want_vld) begin
        errors++; $display("FAIL pipe_vld t%0d: got %b want %b", t, rd_valid3, want_vld);
      end
      if (want_vld) begin
        for (int w = 0; w < 3; w++) want[w*32 +: 32] = m3[w][t-1];
        checks++;
        if (rd_data3 !== want) begin
          errors++; $display("FAIL pipe_dat t%0d: got %h want %h", t, rd_data3, want);
        end
      end
    end
  endtask

  task automatic test_illegal_way();
    logic [31:0] d;
    d = $urandom;
    wr_en = 1'b1; wr_way = 2'd3; wr_addr = 9'h030; wr_byte_en = 4'hF; wr_data = d;
    tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 9'h030;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data4 !== {d, 96'h0}) begin
      errors++; $display("FAIL way3_legal: got %h want %h", rd_data4, {d, 96'h0});
    end
    tick();
    checks++;
    if (rd_data3 !== 96'h0 || rd_valid3 !== 1'b1) begin
      errors++; $display("FAIL way3_dropped: got %h/%b want 0/1", rd_data3, rd_valid3);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 600; i++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_way     = 2'($urandom_range(0, 3));
      wr_addr    = 9'($urandom_range(0, 7));
      wr_byte_en = 4'($urandom);
      wr_data    = $urandom;
      rd_en      = ($urandom_range(0, 9) < 7);
      rd_addr    = 9'($urandom_range(0, 7));
      tick();
      checks++;
      if (rd_valid4 !== exp4_vld || rd_data4 !== exp4) begin
        errors++; $display("FAIL rand4 cyc %0d: got %h/%b want %h/%b", i, rd_data4, rd_valid4, exp4, exp4_vld);
      end
      checks++;
      if (rd_valid3 !== exp3_vld || rd_data3 !== exp3) begin
        errors++; $display("FAIL rand3 cyc %0d: got %h/%b want %h/%b", i, rd_data3, rd_valid3, exp3, exp3_vld);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt;
    rd_en = 1'b1; rd_addr = 9'd3;
    tick();
    tick();
    assert_reset();
    checks++;
    if (rd_valid4 !== 1'b0 || rd_data4 !== 128'h0 || rd_valid3 !== 1'b0 || rd_data3 !== 96'h0) begin
      errors++; $display("FAIL rst_flight: got %h/%b %h/%b want zeros", rd_data4, rd_valid4, rd_data3, rd_valid3);
    end
    rd_en = 1'b0;
    release_reset();
    tick();
    checks++;
    if (rd_valid3 !== 1'b0) begin errors++; $display("FAIL rst_discard: got %b want 0", rd_valid3); end
    repeat (99) tick();
    checks++;
    if (busy4 !== exp_busy) begin errors++; $display("FAIL mid_busy: got %b want %b", busy4, exp_busy); end
    assert_reset();
    checks++;
    if (rd_valid4 !== 1'b0 || rd_data4 !== 128'h0 || busy4 !== exp_busy) begin
      errors++; $display("FAIL rst_mid: got %h/%b busy %b want 0/0 busy %b", rd_data4, rd_valid4, busy4, exp_busy);
    end
    release_reset();
    busy_cnt = busy4 ? 1 : 0;
    for (int i = 0; i < 600 && busy4 !== 1'b0; i++) begin
      tick();
      if (busy4 === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt !== CLEAR_CYCLES || busy4 !== 1'b0) begin
      errors++; $display("FAIL restart_len: got %0d cycles busy %b want %0d cycles busy 0", busy_cnt, busy4, CLEAR_CYCLES);
    end
    for (int a = 0; a < 8; a++) begin
      rd_en = 1'b1; rd_addr = a[8:0];
      tick();
      checks++;
      if (rd_valid4 !== 1'b1 || rd_data4 !== exp4) begin
        errors++; $display("FAIL post_rst addr %0d: got %h/%b want %h/1", a, rd_data4, rd_valid4, exp4);
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_enable();
    test_collision();
    test_pipeline();
    test_illegal_way();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_data_ram.md
# dcache_data_ram

Parametrised single-clock data array for the Cortex-M1 data cache, successor to the fixed 512x32 byte-enabled SDPRAM used per way. Holds NUM_WAYS ways behind one write port and one all-ways read port. Byte-merged read-during-write forwarding, an optional output register stage, and an optional post-reset clear sequencer are built in. Sits between the dcache controller (tag compare, way select) and the AHB refill/store path.

## Interface
- ADDR_WIDTH, 9, entry address width; depth = 2**ADDR_WIDTH per way
- DATA_WIDTH, 32, bits per entry per way
- BYTE_SIZE, 8, bits per byte lane (8 or 9); DATA_WIDTH must be a multiple of it
- NUM_WAYS, 4, number of ways (1..8)
- OUTPUT_REG, 0, 1 adds a registered output stage
- clk  in  1  the only clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_way  in  WAY_W  target way; WAY_W = max(1, clog2(NUM_WAYS))
- wr_addr  in  ADDR_WIDTH  write entry
- wr_byte_en  in  BE_WIDTH  per-lane write enable; BE_WIDTH = DATA_WIDTH/BYTE_SIZE
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request; reads all ways at rd_addr
- rd_addr  in  ADDR_WIDTH  read entry
- rd_data  out  NUM_WAYS*DATA_WIDTH  way w at bits [w*DATA_WIDTH +: DATA_WIDTH]
- rd_valid  out  1  rd_data holds the result of an accepted read
- init_busy  out  1  clear sequencer active; all requests ignored

## Operation
- Write accepted when wr_en=1 and init_busy=0: for each lane b with wr_byte_en[b]=1, way wr_way entry wr_addr lane b takes wr_data lane b. Other lanes and ways unchanged.
- Read accepted when rd_en=1 and init_busy=0: every way at rd_addr is read.
- Collision (write and read accepted in the same cycle, wr_addr==rd_addr): way wr_way returns old data with enabled lanes replaced by wr_data (write-first); other ways return stored data. No forwarding across cycles is needed, since the write is already in the array by the next read.
- wr_way >= NUM_WAYS: write dropped.
- rd_data holds its last value when no read completes. rd_valid pulses one cycle per accepted read.
- Requests with init_busy=1 are dropped silently, not queued.

## Timing
- OUTPUT_REG=0: read accepted in cycle N gives rd_data/rd_valid in cycle N+1.
- OUTPUT_REG=1: rd_data/rd_valid in cycle N+2. Back-to-back reads are fully pipelined, one per cycle.
- Reset values: rd_data=0, rd_valid=0, pipeline valid bits=0. init_busy=1 with DCACHE_RAM_INIT_EN, else 0.
- Clear sequencer states:
  - IDLE -> CLEAR on reset.
  - CLEAR writes zero to counter address in all ways each cycle. The counter runs 0..2**ADDR_WIDTH-1 and does not wrap.
  - CLEAR -> DONE after the last address. init_busy falls the same edge.
  - Default config: init_busy high for exactly 512 cycles after rst_n rises. First request accepted in cycle 512.
- Reset mid-operation: in-flight reads are discarded (rd_valid=0) and the sequencer restarts from address 0. A reset asserted during CLEAR restarts the clear.
- Array contents are not reset except by the sequencer.

## Configuration
- DCACHE_RAM_INIT_EN defined: clear sequencer present; all ways read 0 after init completes.
- Undefined: no sequencer or counter; init_busy is constant 0 and requests are accepted from the first cycle after reset. Contents are uninitialised (X in simulation).

## Structure
- Package dcache_ram_pkg:
  - function for WAY_W
  - BE_WIDTH derivation
  - sequencer state enum (IDLE, CLEAR, DONE)
- Sub-module sdpram_way:
  - one way: byte-enabled write, registered read, same-cycle write-first merge
  - instantiated NUM_WAYS times by generate
- Top level holds: sequencer, way decode, request gating, optional output register.

## Test plan
- Clear: release rst_n, hold rd_en=1 with rd_addr=5 -> init_busy=1 for 512 cycles, no rd_valid. Then a read of 0x1FF returns all-zero on every way, 1 cycle later.
- Byte-enable: write way 2, addr 0x010, 0xAABBCCDD, BE=4'b1111. Then write 0x11223344, BE=4'b0101. Read 0x010 -> way 2 = 0xAA22CC44, ways 0,1,3 = 0.
- Collision: write way 1, addr 0x020, 0xDEADBEEF, BE=4'b0011 in the same cycle as a read of 0x020 (old value 0x12345678) -> way 1 = 0x1234BEEF next cycle, other ways unchanged.
- Pipeline: OUTPUT_REG=1, reads of addr 1,2,3 on consecutive cycles -> rd_valid high for cycles N+2..N+4 with data in order.
- Reset mid-clear: pull rst_n low at cycle 100 of CLEAR -> rd_valid=0, rd_data=0 immediately. After release, init_busy is high for a full 512 cycles.
- Illegal way: NUM_WAYS=3, write with wr_way=3 -> all ways unchanged on readback.
